// File: rtl/soi_probe_bank.sv
// soi_probe_bank: bank of autonomously stepping probe channels with host override,
// registered read port and sticky out-of-range error flag.
// Optional snapshot registers (snap strobe, rd_src select) under SOI_PROBE_SNAPSHOT_EN.
module soi_probe_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned INIT     = 1,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode_we,
    input  logic [CW-1:0]             mode_ch,
    input  logic [1:0]                mode_val,
    input  logic                      wr_en,
    input  logic [CW-1:0]             wr_ch,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic [CW-1:0]             rd_ch,
    input  logic                      rd_src,
    input  logic                      snap,
    output logic                      rd_valid,
    output logic [WIDTH-1:0]          rd_data,
    output logic [CHANNELS*WIDTH-1:0] probe_out,
    output logic                      err
);

    typedef enum logic [1:0] {
        ModeHold   = 2'b00,
        ModeToggle = 2'b01,
        ModeCount  = 2'b10,
        ModeRotate = 2'b11
    } mode_e;

    localparam int unsigned NIDX = 1 << CW;
    localparam logic [WIDTH-1:0] INIT_V = INIT[WIDTH-1:0];

    // One bit per encodable index: set when that index names a real channel.
    function automatic logic [NIDX-1:0] ok_mask();
        logic [NIDX-1:0] m;
        for (int unsigned i = 0; i < NIDX; i++) begin
            m[i] = (i < CHANNELS);
        end
        return m;
    endfunction

    localparam logic [NIDX-1:0] IDX_OK = ok_mask();

    // For WIDTH = 1 the rotate collapses to hold and +1 to invert with no special case.
    function automatic logic [WIDTH-1:0] step(input mode_e m, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (m)
            ModeHold:   r = v;
            ModeToggle: r = ~v;
            ModeCount:  r = v + 1'b1;
            default:    r = (v << 1) | (v >> (WIDTH - 1));
        endcase
        return r;
    endfunction

    logic [CHANNELS-1:0][WIDTH-1:0] chan_q, chan_d;
    mode_e [CHANNELS-1:0]           mode_q, mode_d;
    logic                           rd_valid_q;
    logic [WIDTH-1:0]               rd_data_q, rd_data_d;
    logic                           err_q, err_d;
    logic [WIDTH-1:0]               rd_live, rd_sel;

    // Channel and mode next state: host write beats the autonomous step.
    always_comb begin
        chan_d = chan_q;
        mode_d = mode_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            chan_d[i] = step(mode_q[i], chan_q[i]);
            if (wr_en && wr_ch == CW'(i)) begin
                chan_d[i] = wr_data;
            end
            if (mode_we && mode_ch == CW'(i)) begin
                mode_d[i] = mode_e'(mode_val);
            end
        end
    end

    // Live read mux; out-of-range indices match nothing and yield zero.
    always_comb begin
        rd_live = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CW'(i)) begin
                rd_live = chan_q[i];
            end
        end
    end

`ifdef SOI_PROBE_SNAPSHOT_EN
    logic [CHANNELS-1:0][WIDTH-1:0] snap_q;
    logic [WIDTH-1:0]               rd_snap;

    // Snapshot captures pre-update values, so a same-cycle write is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= {CHANNELS{INIT_V}};
        end else if (snap) begin
            snap_q <= chan_q;
        end
    end

    // Snapshot read mux.
    always_comb begin
        rd_snap = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CW'(i)) begin
                rd_snap = snap_q[i];
            end
        end
    end

    assign rd_sel = rd_src ? rd_snap : rd_live;
`else
    logic unused_snap_inputs;
    assign unused_snap_inputs = snap ^ rd_src;
    assign rd_sel = rd_live;
`endif

    // Read response data and sticky error next state.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = IDX_OK[rd_ch] ? rd_sel : '0;
        end
        err_d = err_q
              | (mode_we & ~IDX_OK[mode_ch])
              | (wr_en & ~IDX_OK[wr_ch])
              | (rd_en & ~IDX_OK[rd_ch]);
    end

    // State registers; reset also drops any in-flight read response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                chan_q[i] <= INIT_V;
                mode_q[i] <= ModeToggle;
            end
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            chan_q     <= chan_d;
            mode_q     <= mode_d;
            rd_valid_q <= rd_en;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    assign probe_out = chan_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_soi_probe_bank.sv
// Directed bench for soi_probe_bank: a 4x8 instance for the main function and a
// 3x1 instance (INIT=3, truncated to 1) for out-of-range indices and 1-bit modes.
module tb_soi_probe_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance: CHANNELS=4, WIDTH=8, INIT=1
    logic        rst;
    logic        mode_we, wr_en, rd_en, rd_src, snap;
    logic [1:0]  mode_ch, wr_ch, rd_ch, mode_val;
    logic [7:0]  wr_data;
    logic        rd_valid, err;
    logic [7:0]  rd_data;
    logic [31:0] probe_out;

    soi_probe_bank #(.CHANNELS(4), .WIDTH(8), .INIT(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode_we   (mode_we),
        .mode_ch   (mode_ch),
        .mode_val  (mode_val),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_ch     (rd_ch),
        .rd_src    (rd_src),
        .snap      (snap),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .probe_out (probe_out),
        .err       (err)
    );

    // Second instance: CHANNELS=3, WIDTH=1, INIT=3
    logic       d3_rst;
    logic       d3_mode_we, d3_wr_en, d3_rd_en;
    logic [1:0] d3_mode_ch, d3_wr_ch, d3_rd_ch, d3_mode_val;
    logic [0:0] d3_wr_data, d3_rd_data;
    logic       d3_rd_valid, d3_err;
    logic [2:0] d3_probe_out;

    soi_probe_bank #(.CHANNELS(3), .WIDTH(1), .INIT(3)) u_dut3 (
        .clk       (clk),
        .rst       (d3_rst),
        .mode_we   (d3_mode_we),
        .mode_ch   (d3_mode_ch),
        .mode_val  (d3_mode_val),
        .wr_en     (d3_wr_en),
        .wr_ch     (d3_wr_ch),
        .wr_data   (d3_wr_data),
        .rd_en     (d3_rd_en),
        .rd_ch     (d3_rd_ch),
        .rd_src    (1'b0),
        .snap      (1'b0),
        .rd_valid  (d3_rd_valid),
        .rd_data   (d3_rd_data),
        .probe_out (d3_probe_out),
        .err       (d3_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; d3_rst = 1'b1;
        mode_we = 0; mode_ch = 0; mode_val = 0; wr_en = 0; wr_ch = 0; wr_data = 0;
        rd_en = 0; rd_ch = 0; rd_src = 0; snap = 0;
        d3_mode_we = 0; d3_mode_ch = 0; d3_mode_val = 0; d3_wr_en = 0; d3_wr_ch = 0;
        d3_wr_data = 0; d3_rd_en = 0; d3_rd_ch = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (probe_out !== 32'h01010101) begin
            errors++; $display("FAIL reset_probe: got %h want %h", probe_out, 32'h01010101);
        end
        checks++;
        if ({rd_valid, rd_data, err} !== 10'h000) begin
            errors++; $display("FAIL reset_outs: got v=%b d=%h e=%b want 0", rd_valid, rd_data, err);
        end
        checks++;
        if (d3_probe_out !== 3'b111) begin
            errors++; $display("FAIL reset_init_trunc: got %b want 111", d3_probe_out);
        end
    endtask

    task automatic test_toggle();
        rst = 1'b0; rd_en = 1'b1; rd_ch = 2'd0; rd_src = 1'b0;
        @(negedge clk);
        checks++;
        if (probe_out[7:0] !== 8'hFE || rd_valid !== 1'b1 || rd_data !== 8'h01) begin
            errors++; $display("FAIL toggle_c1: got ch0=%h v=%b d=%h want FE 1 01",
                probe_out[7:0], rd_valid, rd_data);
        end
        @(negedge clk);
        checks++;
        if (probe_out[7:0] !== 8'h01 || rd_valid !== 1'b1 || rd_data !== 8'hFE) begin
            errors++; $display("FAIL toggle_c2: got ch0=%h v=%b d=%h want 01 1 FE",
                probe_out[7:0], rd_valid, rd_data);
        end
        rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (probe_out !== 32'hFEFEFEFE || rd_valid !== 1'b0 || rd_data !== 8'hFE) begin
            errors++; $display("FAIL toggle_c3_hold: got p=%h v=%b d=%h want FEFEFEFE 0 FE",
                probe_out, rd_valid, rd_data);
        end
    endtask

    task automatic test_count_wrap();
        mode_we = 1; mode_ch = 2'd2; mode_val = 2'b10;
        wr_en = 1; wr_ch = 2'd2; wr_data = 8'hFF;
        @(negedge clk);
        mode_we = 0; wr_en = 0;
        checks++;
        if (probe_out[23:16] !== 8'hFF || probe_out[7:0] !== 8'h01) begin
            errors++; $display("FAIL count_load: got ch2=%h ch0=%h want FF 01",
                probe_out[23:16], probe_out[7:0]);
        end
        @(negedge clk);
        checks++;
        if (probe_out[23:16] !== 8'h00) begin
            errors++; $display("FAIL count_wrap: got %h want 00", probe_out[23:16]);
        end
        @(negedge clk);
        checks++;
        if (probe_out !== 32'h01010101) begin
            errors++; $display("FAIL count_after_wrap: got %h want 01010101", probe_out);
        end
    endtask

    task automatic test_write_read();
        // Mode write: this edge still steps ch1 under TOGGLE.
        mode_we = 1; mode_ch = 2'd1; mode_val = 2'b10;
        @(negedge clk);
        mode_we = 0;
        checks++;
        if (probe_out !== 32'hFE02FEFE) begin
            errors++; $display("FAIL mode_old_step: got %h want FE02FEFE", probe_out);
        end
        wr_en = 1; wr_ch = 2'd1; wr_data = 8'h40;
        rd_en = 1; rd_ch = 2'd1; rd_src = 0;
        @(negedge clk);
        wr_en = 0; rd_en = 0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hFE) begin
            errors++; $display("FAIL wr_rd_prewrite: got v=%b d=%h want 1 FE", rd_valid, rd_data);
        end
        checks++;
        if (probe_out !== 32'h01034001) begin
            errors++; $display("FAIL wr_override: got %h want 01034001", probe_out);
        end
        @(negedge clk);
        checks++;
        if (probe_out !== 32'hFE0441FE || rd_valid !== 1'b0) begin
            errors++; $display("FAIL wr_then_count: got p=%h v=%b want FE0441FE 0",
                probe_out, rd_valid);
        end
    endtask

    task automatic test_mode_hold();
        mode_we = 1; mode_ch = 2'd0; mode_val = 2'b00;
        @(negedge clk);
        mode_we = 0;
        checks++;
        if (probe_out[7:0] !== 8'h01) begin
            errors++; $display("FAIL hold_last_toggle: got %h want 01", probe_out[7:0]);
        end
        @(negedge clk);
        checks++;
        if (probe_out !== 32'hFE0643_01) begin
            errors++; $display("FAIL hold_keeps: got %h want FE064301", probe_out);
        end
    endtask

    task automatic test_rotate_snap();
        logic [7:0] exp_snap3, exp_snap0;
`ifdef SOI_PROBE_SNAPSHOT_EN
        exp_snap3 = 8'h81; exp_snap0 = 8'h01;
`else
        exp_snap3 = 8'h03; exp_snap0 = 8'hAA;
`endif
        mode_we = 1; mode_ch = 2'd3; mode_val = 2'b11;
        wr_en = 1; wr_ch = 2'd3; wr_data = 8'h81;
        @(negedge clk);
        mode_we = 0;
        checks++;
        if (probe_out[31:24] !== 8'h81) begin
            errors++; $display("FAIL rot_load: got %h want 81", probe_out[31:24]);
        end
        snap = 1; wr_ch = 2'd0; wr_data = 8'hAA;
        @(negedge clk);
        snap = 0; wr_en = 0;
        checks++;
        if (probe_out[31:24] !== 8'h03 || probe_out[7:0] !== 8'hAA) begin
            errors++; $display("FAIL rot_step: got ch3=%h ch0=%h want 03 AA",
                probe_out[31:24], probe_out[7:0]);
        end
        rd_en = 1; rd_ch = 2'd3; rd_src = 1;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_snap3) begin
            errors++; $display("FAIL snap_rd_ch3: got v=%b d=%h want 1 %h", rd_valid, rd_data, exp_snap3);
        end
        rd_src = 0;
        @(negedge clk);
        checks++;
        if (rd_data !== 8'h06 || probe_out[31:24] !== 8'h0C) begin
            errors++; $display("FAIL live_rd_ch3: got d=%h ch3=%h want 06 0C", rd_data, probe_out[31:24]);
        end
        rd_ch = 2'd0; rd_src = 1;
        @(negedge clk);
        checks++;
        if (rd_data !== exp_snap0) begin
            errors++; $display("FAIL snap_vs_write: got %h want %h", rd_data, exp_snap0);
        end
        rd_src = 0;
        @(negedge clk);
        rd_en = 0;
        checks++;
        if (rd_data !== 8'hAA || rd_valid !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL live_rd_ch0: got d=%h v=%b e=%b want AA 1 0", rd_data, rd_valid, err);
        end
    endtask

    task automatic test_reset_pending();
        rd_en = 1; rd_ch = 2'd1;
        @(posedge clk);
        #1;
        rst = 1; rd_en = 0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || probe_out !== 32'h01010101) begin
            errors++; $display("FAIL rst_async: got v=%b d=%h p=%h want 0 00 01010101",
                rd_valid, rd_data, probe_out);
        end
        @(negedge clk);
        rst = 0;
        checks++;
        if (rd_valid !== 1'b0 || probe_out !== 32'h01010101) begin
            errors++; $display("FAIL rst_release: got v=%b p=%h want 0 01010101", rd_valid, probe_out);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || probe_out !== 32'hFEFEFEFE) begin
            errors++; $display("FAIL rst_first_step: got v=%b p=%h want 0 FEFEFEFE", rd_valid, probe_out);
        end
    endtask

    task automatic test_out_of_range_w1();
        d3_rst = 0; d3_rd_en = 1; d3_rd_ch = 2'd0;
        @(negedge clk);
        checks++;
        if (d3_rd_valid !== 1'b1 || d3_rd_data !== 1'b1 || d3_err !== 1'b0 || d3_probe_out !== 3'b000) begin
            errors++; $display("FAIL w1_rd_inrange: got v=%b d=%b e=%b p=%b want 1 1 0 000",
                d3_rd_valid, d3_rd_data, d3_err, d3_probe_out);
        end
        d3_rd_ch = 2'd3;
        @(negedge clk);
        checks++;
        if (d3_rd_valid !== 1'b1 || d3_rd_data !== 1'b0 || d3_err !== 1'b1 || d3_probe_out !== 3'b111) begin
            errors++; $display("FAIL oor_read: got v=%b d=%b e=%b p=%b want 1 0 1 111",
                d3_rd_valid, d3_rd_data, d3_err, d3_probe_out);
        end
        d3_rd_en = 0; d3_mode_we = 1; d3_mode_ch = 2'd0; d3_mode_val = 2'b10;
        @(negedge clk);
        checks++;
        if (d3_rd_valid !== 1'b0 || d3_err !== 1'b1 || d3_probe_out !== 3'b000) begin
            errors++; $display("FAIL oor_sticky: got v=%b e=%b p=%b want 0 1 000",
                d3_rd_valid, d3_err, d3_probe_out);
        end
        d3_mode_ch = 2'd1; d3_mode_val = 2'b11;
        @(negedge clk);
        d3_mode_ch = 2'd2; d3_mode_val = 2'b00;
        @(negedge clk);
        d3_mode_we = 0;
        checks++;
        if (d3_probe_out !== 3'b010) begin
            errors++; $display("FAIL w1_modes_a: got %b want 010", d3_probe_out);
        end
        @(negedge clk);
        checks++;
        if (d3_probe_out !== 3'b011) begin
            errors++; $display("FAIL w1_modes_b: got %b want 011", d3_probe_out);
        end
        @(negedge clk);
        checks++;
        if (d3_probe_out !== 3'b010 || d3_err !== 1'b1) begin
            errors++; $display("FAIL w1_modes_c: got p=%b e=%b want 010 1", d3_probe_out, d3_err);
        end
        d3_rst = 1;
        @(negedge clk);
        checks++;
        if (d3_err !== 1'b0 || d3_probe_out !== 3'b111) begin
            errors++; $display("FAIL oor_cleared: got e=%b p=%b want 0 111", d3_err, d3_probe_out);
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_count_wrap();
        test_write_read();
        test_mode_hold();
        test_rotate_snap();
        test_reset_pending();
        test_out_of_range_w1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
